// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU datapath blocks.
//   ALU_WIDTH / ALU_CHUNK : default operand width and per-cycle slice width
//   ST_IDLE / ST_RUN / ST_DONE : sequencer state encoding for rca_seq
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_CHUNK = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rca_n.sv
// fa_cell: single-bit full adder.
//   a, b, c_in : addend bits and carry in
//   s, c_out   : sum bit and carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// rca_n: combinational N-bit ripple-carry adder built from fa_cell.
//   a, b   : N-bit addends
//   c_in   : carry into bit 0
//   s      : N-bit sum
//   c_out  : carry out of bit N-1
//   c_msb  : carry into bit N-1 (used by the caller for signed overflow)
module rca_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         c_msb
);
    logic [N:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa_cell u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (c[i]),
            .s     (s[i]),
            .c_out (c[i+1])
        );
    end

    assign c_out = c[N];
    assign c_msb = c[N-1];
endmodule

// File: rtl/rca_seq.sv
// rca_seq: multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per
// clock through a single reused ripple-carry slice.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : request, accepted in IDLE or DONE
//   sub        : 0 = x+y, 1 = x-y (sampled with start)
//   x, y       : operands (sampled with start)
//   busy       : slice computation in progress
//   done       : one-cycle pulse when z/c_out/ovf are complete
//   z          : result
//   c_out      : carry out of the top bit (for sub, 1 = no borrow)
//   ovf        : two's-complement overflow
//
// state   | meaning
// IDLE    | waiting for start, last result held
// RUN     | one slice per cycle, NCHUNK cycles
// DONE    | result complete, done pulse; start here chains the next op
module rca_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = ALU_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] z_shift;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    rca_n #(.N(CHUNK)) u_slice (
        .a     (a_reg[CHUNK-1:0]),
        .b     (b_reg[CHUNK-1:0]),
        .c_in  (carry),
        .s     (slice_sum),
        .c_out (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Results enter z from the top so after NCHUNK slices slice 0 sits at
    // the bottom. The single-slice case has nothing to shift.
    if (NCHUNK == 1) begin : g_single
        assign z_shift = slice_sum;
        assign a_shift = '0;
        assign b_shift = '0;
    end else begin : g_multi
        assign z_shift = {slice_sum, z[WIDTH-1:CHUNK]};
        assign a_shift = {{CHUNK{1'b0}}, a_reg[WIDTH-1:CHUNK]};
        assign b_shift = {{CHUNK{1'b0}}, b_reg[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as x + ~y + 1: the +1 rides in as carry-in.
                        a_reg <= x;
                        b_reg <= sub ? ~y : y;
                        carry <= sub;
                        cnt   <= '0;
                        z     <= '0;
                        c_out <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_reg <= a_shift;
                    b_reg <= b_shift;
                    carry <= slice_cout;
                    z     <= z_shift;
                    if (cnt == LAST) begin
                        c_out <= slice_cout;
                        // Carry into the sign bit differing from carry out of
                        // it is the same as "operand signs equal, sum sign
                        // differs" for the (possibly inverted) b operand.
                        ovf   <= slice_cmsb ^ slice_cout;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/rca_seq.md
# rca_seq

Parametrised multi-cycle adder/subtractor for the 64-bit ALU datapath. Processes a WIDTH-bit add or subtract in CHUNK-bit slices, one slice per clock, through a single reused ripple-carry slice adder, trading latency for area against the flat 64-bit adder. Sits beside the combinational arithmetic unit behind a start/done handshake and reports carry-out and signed overflow.

## Interface
- WIDTH, 64: operand/result width; WIDTH % CHUNK == 0 required.
- CHUNK, 8: bits processed per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = x+y, 1 = x−y; sampled with start.
- x  in  WIDTH  operand A; sampled with start.
- y  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while a slice computation is in progress.
- done  out  1  one-cycle pulse when the result is complete.
- z  out  WIDTH  result.
- c_out  out  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with start=1: load a ← x, b ← sub ? ~y : y, carry ← sub, slice counter ← 0, z/c_out/ovf ← 0; go RUN. DONE with start=0 → IDLE.
- RUN, each cycle: slice adder sums a[CHUNK−1:0] + b[CHUNK−1:0] + carry; sum shifts into z from the top (z ← {sum, z[WIDTH−1:CHUNK]}); a, b shift right by CHUNK; carry ← slice carry-out; counter increments.
- Last slice (counter = NCHUNK−1): c_out ← slice carry-out; ovf ← (a_msb == b_msb) && (sum_msb != a_msb), using the inverted b for sub; go DONE.
- start is ignored in RUN; x, y, sub are don't-care outside the accepting cycle.
- z, c_out, ovf hold their value in DONE and IDLE until the next accepted start.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: busy=0, done=0, z=0, c_out=0, ovf=0, state IDLE, counter 0. Reset mid-RUN aborts the operation immediately; no done pulse follows.
- start accepted at edge E0 → busy=1 from E0 to E(NCHUNK); slice i written at edge E(i+1).
- done=1 for exactly the cycle after E(NCHUNK); z, c_out, ovf valid from that cycle on. Latency start→done = NCHUNK cycles (8 at defaults).
- Back-to-back: start=1 during the done cycle is accepted; results are cleared at that edge; the next done follows NCHUNK cycles later. Throughput: one result per NCHUNK+1 cycles max.
- busy and done never both high. All outputs registered.
- CHUNK = WIDTH degenerates to NCHUNK=1: one RUN cycle, done one cycle after start.

## Structure
- Shared package alu_pkg: state encoding (IDLE, RUN, DONE) and default width constants (ALU_WIDTH=64, ALU_CHUNK=8).
- Sub-module rca_n (parameter N): combinational N-bit ripple-carry adder built from the existing full-adder cell via generate, with c_in, c_out, and carry into bit N−1 exported. One instance, N=CHUNK.
- rca_seq holds the FSM, counter (width clog2(NCHUNK), minimum 1), operand/result shift registers, and flag logic.

## Test plan
- Defaults, x=0x0000_0000_FFFF_FFFF, y=1, sub=0 → done 8 cycles after start; z=0x0000_0001_0000_0000, c_out=0, ovf=0; busy high for 8 cycles.
- x=0x7FFF_FFFF_FFFF_FFFF, y=1, sub=0 → z=0x8000_0000_0000_0000, ovf=1, c_out=0; x=0xFFFF_FFFF_FFFF_FFFF, y=1 → z=0, c_out=1, ovf=0.
- sub=1, x=5, y=7 → z=0xFFFF_FFFF_FFFF_FFFE, c_out=0; x=0x8000_0000_0000_0000, y=1 → z=0x7FFF_FFFF_FFFF_FFFF, ovf=1, c_out=1.
- start pulsed during RUN with different operands → ignored; first result unchanged. start held during the done cycle → second op accepted, its done exactly 9 cycles after the first done.
- rst asserted at cycle 4 of RUN → all outputs 0 immediately (asynchronous), no done; fresh start afterward completes correctly.
- WIDTH=32, CHUNK=4 and WIDTH=16, CHUNK=16: 1000 random add/sub ops vs reference model → z, c_out, ovf match; latency NCHUNK.
